fft8_sequencer: RTL

//   Iterative 8-point radix-2 DIT FFT engine built around ONE shared combinational `butterfly`.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft8_sequencer_butterfly.sv | 63 ++++++
 rtl/fft8_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and index helpers for the iterative 8-point FFT sequencer.
package fft_pkg;

    localparam int FFT_DATA_W = 16;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        UNLOAD
    } state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Twiddle exponent in W8 units: pos * (4 >> stage).
    function automatic logic [2:0] twiddle_k(input logic [1:0] stage, input logic [2:0] pos);
        logic [2:0] step;
        step = 3'd4 >> stage;
        return 3'(pos * step);
    endfunction

endpackage

// File: rtl/fft8_sequencer_butterfly.sv
// Radix-2 DIT butterfly: A + W8^k*B and A - W8^k*B, twiddles in Q1.14, round-half-up, wrapping sums.
module butterfly
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic        [2:0]        k,
    output logic signed [DATA_W-1:0] oa_re,
    output logic signed [DATA_W-1:0] oa_im,
    output logic signed [DATA_W-1:0] ob_re,
    output logic signed [DATA_W-1:0] ob_im
);

    localparam int FRAC = 14;
    localparam int PW   = DATA_W + 17;
    localparam logic signed [15:0] W_ONE = 16'sd16384;
    localparam logic signed [15:0] W_C   = 16'sd11585;
    localparam logic signed [PW-1:0] ROUND = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    logic signed [15:0]       w_re;
    logic signed [15:0]       w_im;
    logic signed [PW-1:0]     prod_re;
    logic signed [PW-1:0]     prod_im;
    logic signed [DATA_W-1:0] t_re;
    logic signed [DATA_W-1:0] t_im;
    logic                     unused_bits;

    // W8^k = exp(-j*2*pi*k/8)
    always_comb begin
        w_re = W_ONE;
        w_im = '0;
        case (k)
            3'd0: begin w_re = W_ONE;  w_im = '0;     end
            3'd1: begin w_re = W_C;    w_im = -W_C;   end
            3'd2: begin w_re = '0;     w_im = -W_ONE; end
            3'd3: begin w_re = -W_C;   w_im = -W_C;   end
            3'd4: begin w_re = -W_ONE; w_im = '0;     end
            3'd5: begin w_re = -W_C;   w_im = W_C;    end
            3'd6: begin w_re = '0;     w_im = W_ONE;  end
            3'd7: begin w_re = W_C;    w_im = W_C;    end
            default: ;
        endcase
    end

    always_comb begin
        prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + ROUND;
        prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + ROUND;
        t_re    = prod_re[FRAC +: DATA_W];
        t_im    = prod_im[FRAC +: DATA_W];
        oa_re   = a_re + t_re;
        oa_im   = a_im + t_im;
        ob_re   = a_re - t_re;
        ob_im   = a_im - t_im;
    end

    assign unused_bits = ^{prod_re[FRAC-1:0], prod_re[PW-1:FRAC+DATA_W],
                           prod_im[FRAC-1:0], prod_im[PW-1:FRAC+DATA_W]};

endmodule

// File: rtl/fft8_sequencer.sv
// Iterative 8-point radix-2 DIT FFT: bit-reversed load, 12 in-place butterfly ops, natural-order unload.
module fft8_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_im,
    output logic        [2:0]        out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    state_t state, next_state;
    logic [2:0] cnt;
    logic [3:0] op;
    logic       load_fire, out_fire;

    logic signed [DATA_W-1:0] mem_re [8];
    logic signed [DATA_W-1:0] mem_im [8];

    logic [1:0] stage;
    logic [2:0] j, span, pos, grp, addr_a, addr_b, k;
    logic signed [DATA_W-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    // Handshake outputs are gated by rst so nothing is offered while reset is held.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load_fire  = 1'b0;
        out_fire   = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = !rst;
                load_fire = in_valid && !rst;
                if (load_fire && cnt == 3'd7) next_state = CALC;
            end
            CALC: begin
                busy = !rst;
                if (op == 4'd11) next_state = UNLOAD;
            end
            UNLOAD: begin
                out_valid = !rst;
                busy      = !rst;
                out_fire  = out_ready && !rst;
                if (out_fire && cnt == 3'd7) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            op   <= '0;
            done <= 1'b0;
        end else begin
            done <= out_fire && (cnt == 3'd7);
            if (load_fire || out_fire) cnt <= cnt + 3'd1;
            if (state == CALC && op != 4'd11) op <= op + 4'd1;
            else                              op <= '0;
        end
    end

    always_comb begin
        stage  = op[3:2];
        j      = {1'b0, op[1:0]};
        span   = 3'd1 << stage;
        pos    = j & (span - 3'd1);
        grp    = j >> stage;
        addr_a = (grp << (stage + 2'd1)) + pos;
        addr_b = addr_a + span;
        k      = twiddle_k(stage, pos);
    end

    butterfly #(.DATA_W(DATA_W)) u_butterfly (
        .a_re  (mem_re[addr_a]),
        .a_im  (mem_im[addr_a]),
        .b_re  (mem_re[addr_b]),
        .b_im  (mem_im[addr_b]),
        .k     (k),
        .oa_re (bf_a_re),
        .oa_im (bf_a_im),
        .ob_re (bf_b_re),
        .ob_im (bf_b_im)
    );

    // Sample buffer carries no reset; every entry is rewritten by the next load.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_re[bitrev3(cnt)] <= in_real;
            mem_im[bitrev3(cnt)] <= in_im;
        end else if (state == CALC) begin
            mem_re[addr_a] <= bf_a_re;
            mem_im[addr_a] <= bf_a_im;
            mem_re[addr_b] <= bf_b_re;
            mem_im[addr_b] <= bf_b_im;
        end
    end

    assign out_real  = mem_re[cnt];
    assign out_im    = mem_im[cnt];
    assign out_index = cnt;
    assign out_last  = out_valid && (cnt == 3'd7);

endmodule
